// File: rtl/mac_accumulator_if.sv
// Operand and result handshake bundle for mac_accumulator.
// master: producer/consumer side; slave: the accumulator.
interface mac_accumulator_if #(parameter int ACC_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, acc_out, overflow);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, acc_out, overflow);
endinterface

// File: rtl/mac_accumulator.sv
// Frame multiply-accumulate behind a 4x4 array multiplier; sums COUNT products.
// Optional MAC_SATURATE_EN clamps the frame sum at 2^ACC_W-1 instead of wrapping.
module array_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // One partial-product row per multiplier bit, summed row by row.
  logic [3:0][7:0] pp;
  logic [4:0][7:0] row;

  assign row[0] = '0;
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign pp[i]    = 8'({4{b[i]}} & a) << i;
    assign row[i+1] = row[i] + pp[i];
  end
  assign p = row[4];
endmodule

module mac_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input logic                clk,
  input logic                rst,
  mac_accumulator_if.slave   bus
);
  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    in_cnt, acc_cnt;
  logic [7:0]       prod_c, prod_r;
  logic             prod_v;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept, last_acc, hs;

  array_multiplier u_mul (.a(bus.a), .b(bus.b), .p(prod_c));

  assign bus.out_valid = (state == HOLD);
  assign bus.in_ready  = (in_cnt < CW'(COUNT)) && !bus.out_valid;
  assign bus.acc_out   = acc;
  assign bus.overflow  = ovf;

  assign accept   = bus.in_valid && bus.in_ready;
  assign hs       = bus.out_valid && bus.out_ready;
  assign last_acc = prod_v && (acc_cnt == CW'(COUNT - 1));
  assign sum      = {1'b0, acc} + (ACC_W+1)'(prod_r);

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && in_cnt == CW'(COUNT - 1)) state_nxt = DRAIN;
      DRAIN: if (last_acc) state_nxt = HOLD;
      HOLD:  if (hs) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) prod_r <= prod_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ovf     <= 1'b0;
      in_cnt  <= '0;
      acc_cnt <= '0;
    end else if (hs) begin
      acc     <= '0;
      ovf     <= 1'b0;
      in_cnt  <= '0;
      acc_cnt <= '0;
    end else begin
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (prod_v) begin
        acc_cnt <= acc_cnt + 1'b1;
`ifdef MAC_SATURATE_EN
        // Once clamped, stay clamped for the rest of the frame.
        acc <= (sum[ACC_W] || ovf) ? '1 : sum[ACC_W-1:0];
`else
        acc <= sum[ACC_W-1:0];
`endif
        if (sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed + randomized frames on two accumulators (ACC_W=16 and ACC_W=8, COUNT=4)
// driven in lockstep and compared against an arithmetic frame-sum model.
module tb_mac_accumulator;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_accumulator_if #(.ACC_W(16)) w16 ();
  mac_accumulator_if #(.ACC_W(8))  w8  ();

  mac_accumulator #(.ACC_W(16), .COUNT(COUNT)) u16 (.clk(clk), .rst(rst), .bus(w16.slave));
  mac_accumulator #(.ACC_W(8),  .COUNT(COUNT)) u8  (.clk(clk), .rst(rst), .bus(w8.slave));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    w16.in_valid = v; w16.a = a; w16.b = b;
    w8.in_valid  = v; w8.a  = a; w8.b  = b;
  endtask

  task automatic set_oready(input logic r);
    w16.out_ready = r;
    w8.out_ready  = r;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  32'(w16.in_ready),  1);
    chk({tag, ".out_valid"}, 32'(w16.out_valid), 0);
    chk({tag, ".acc16"},     32'(w16.acc_out),   0);
    chk({tag, ".ovf16"},     32'(w16.overflow),  0);
    chk({tag, ".acc8"},      32'(w8.acc_out),    0);
    chk({tag, ".ovf8"},      32'(w8.overflow),   0);
  endtask

  // Reference: frame result from the plain integer sum of products.
  function automatic logic [31:0] exp_acc(input int sum, input int w);
    int lim = (1 << w) - 1;
`ifdef MAC_SATURATE_EN
    return (sum > lim) ? 32'(lim) : 32'(sum & lim);
`else
    return 32'(sum & lim);
`endif
  endfunction

  task automatic frame(input logic [3:0] fa [COUNT], input logic [3:0] fb [COUNT],
                       input int gap, input int hold, input string tag);
    int sum = 0;
    logic [31:0] e16, e8, o16, o8;
    for (int i = 0; i < COUNT; i++) begin
      repeat (gap) begin
        drive(1'b0, 4'd0, 4'd0);
        tick();
        chk({tag, ".gap_ready"}, 32'(w16.in_ready && w8.in_ready), 1);
      end
      drive(1'b1, fa[i], fb[i]);
      chk({tag, ".acc_ready"}, 32'(w16.in_ready && w8.in_ready), 1);
      chk({tag, ".early_valid"}, 32'(w16.out_valid || w8.out_valid), 0);
      sum += int'(fa[i]) * int'(fb[i]);
      tick();
    end
    drive(1'b0, 4'd0, 4'd0);
    chk({tag, ".ready_low"}, 32'(w16.in_ready || w8.in_ready), 0);
    chk({tag, ".drain_valid"}, 32'(w16.out_valid || w8.out_valid), 0);
    tick();
    e16 = exp_acc(sum, 16);
    e8  = exp_acc(sum, 8);
    o16 = (sum > 65535) ? 32'd1 : 32'd0;
    o8  = (sum > 255)   ? 32'd1 : 32'd0;
    chk({tag, ".valid16"}, 32'(w16.out_valid), 1);
    chk({tag, ".valid8"},  32'(w8.out_valid),  1);
    chk({tag, ".acc16"},   32'(w16.acc_out),   e16);
    chk({tag, ".ovf16"},   32'(w16.overflow),  o16);
    chk({tag, ".acc8"},    32'(w8.acc_out),    e8);
    chk({tag, ".ovf8"},    32'(w8.overflow),   o8);
    repeat (hold) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(w16.out_valid && w8.out_valid), 1);
      chk({tag, ".hold_acc16"}, 32'(w16.acc_out), e16);
      chk({tag, ".hold_acc8"},  32'(w8.acc_out),  e8);
      chk({tag, ".hold_ovf8"},  32'(w8.overflow), o8);
      chk({tag, ".hold_ready"}, 32'(w16.in_ready || w8.in_ready), 0);
    end
    set_oready(1'b1);
    tick();
    set_oready(1'b0);
    chk_idle({tag, ".clear"});
  endtask

  logic [3:0] fa [COUNT];
  logic [3:0] fb [COUNT];

  initial begin
    drive(1'b0, 4'd0, 4'd0);
    set_oready(1'b0);
    #2;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Basic frame: 15+26+60+225 = 326; ACC_W=8 sees 326 > 255.
    fa = '{4'd3, 4'd13, 4'd6, 4'd15}; fb = '{4'd5, 4'd2, 4'd10, 4'd15};
    frame(fa, fb, 0, 0, "basic");
    frame(fa, fb, 0, 5, "backpressure");

    // 900: wraps to 132 on 8 bits (or clamps to 255), fits in 16 bits.
    fa = '{4'd15, 4'd15, 4'd15, 4'd15}; fb = '{4'd15, 4'd15, 4'd15, 4'd15};
    frame(fa, fb, 0, 0, "ovf");

    fa = '{4'd0, 4'd1, 4'd4, 4'd2}; fb = '{4'd9, 4'd1, 4'd4, 4'd7};
    frame(fa, fb, 3, 1, "bubbles");

    // Reset with two products accepted and one still in flight.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd7, 4'd9);
      tick();
    end
    drive(1'b0, 4'd0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_no_valid", 32'(w16.out_valid || w8.out_valid), 0);
    end
    fa = '{4'd1, 4'd1, 4'd1, 4'd1}; fb = '{4'd1, 4'd1, 4'd1, 4'd1};
    frame(fa, fb, 0, 0, "after_rst");

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < COUNT; i++) begin
        fa[i] = 4'($urandom_range(0, 15));
        fb[i] = 4'($urandom_range(0, 15));
      end
      frame(fa, fb, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
